alu_mdu: RTL

//  Parametrised execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.

---
 rtl/cpu_types_pkg.sv | 48 ++++
 rtl/alu_core.sv | 52 +++++
 rtl/alu_mdu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared opcode and state types for the execute-stage ALU / multiply-divide unit.
package cpu_types_pkg;

    // Single-cycle ALU opcodes.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_ADD  = 4'd8,
        ALU_SUB  = 4'd9
    } aluop_t;

    // Full opcode set of the unit; 0-9 share the ALU encodings, 16-31 are illegal.
    typedef enum logic [4:0] {
        MDU_SLL   = 5'd0,
        MDU_SRL   = 5'd1,
        MDU_AND   = 5'd2,
        MDU_OR    = 5'd3,
        MDU_XOR   = 5'd4,
        MDU_NOR   = 5'd5,
        MDU_SLT   = 5'd6,
        MDU_SLTU  = 5'd7,
        MDU_ADD   = 5'd8,
        MDU_SUB   = 5'd9,
        MDU_MULT  = 5'd10,
        MDU_MULTU = 5'd11,
        MDU_DIV   = 5'd12,
        MDU_DIVU  = 5'd13,
        MDU_MFHI  = 5'd14,
        MDU_MFLO  = 5'd15
    } mduop_t;

    // Control states of the unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam logic [4:0] LAST_ALU_OP = 5'd9;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: shifts, logic, compares, add/sub and their flags.
module alu_core
    import cpu_types_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  aluop_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;

    assign shamt = b[SHAMT_W-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // Operation select; overflow is only meaningful for ADD/SUB.
    always_comb begin
        res      = '0;
        overflow = 1'b0;
        case (op)
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_ADD: begin
                res      = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res      = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default:  res = '0;
        endcase
        zero     = (res == '0);
        negative = res[WIDTH-1];
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative multiply/divide, HI/LO and a valid/ready handshake.
module alu_mdu
    import cpu_types_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             overflow_q, overflow_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] core_res;
    logic             core_zero, core_neg, core_ovf;

    logic req_is_alu, req_is_mul, req_is_div, req_signed, opq_is_mul;

    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Absolute value for signed operands, pass-through otherwise.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .op       (aluop_t'(req_op[3:0])),
        .a        (port_a),
        .b        (port_b),
        .res      (core_res),
        .zero     (core_zero),
        .negative (core_neg),
        .overflow (core_ovf)
    );

    assign req_is_alu = (req_op <= LAST_ALU_OP);
    assign req_is_mul = (req_op == MDU_MULT) || (req_op == MDU_MULTU);
    assign req_is_div = (req_op == MDU_DIV) || (req_op == MDU_DIVU);
    assign req_signed = (req_op == MDU_MULT) || (req_op == MDU_DIV);
    assign opq_is_mul = (op_q == MDU_MULT) || (op_q == MDU_MULTU);

    // One iteration of shift-add multiply and restoring divide on the working pair.
    always_comb begin
        madd   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh = {work_hi_q, work_lo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, mcand_q};
        qbit   = ~trial[WIDTH];
    end

    // Sign correction of the finished magnitude result; divide-by-zero overrides it.
    always_comb begin
        prod_raw = {work_hi_q, work_lo_q};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        if (opq_is_mul) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            fix_hi = negr_q ? -work_hi_q : work_hi_q;
            fix_lo = neg_q ? -work_lo_q : work_lo_q;
        end
    end

    // Next-state and datapath update; flush wins over everything and leaves HI/LO alone.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        count_d    = count_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        mcand_d    = mcand_q;
        neg_d      = neg_q;
        negr_d     = negr_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;
        if (flush) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_d    = req_op;
                        a_d     = port_a;
                        count_d = '0;
                        if (req_is_mul || req_is_div) begin
                            state_d   = ST_CALC;
                            work_hi_d = '0;
                            work_lo_d = mag(port_a, req_signed);
                            mcand_d   = mag(port_b, req_signed);
                            neg_d     = req_signed && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
                            negr_d    = (req_op == MDU_DIV) && port_a[WIDTH-1];
                            dz_d      = req_is_div && (port_b == '0);
                        end else begin
                            state_d    = ST_DONE;
                            overflow_d = 1'b0;
                            dbz_d      = 1'b0;
                            if (req_is_alu) begin
                                result_d   = core_res;
                                zero_d     = core_zero;
                                negative_d = core_neg;
                                overflow_d = core_ovf;
                            end else if (req_op == MDU_MFHI) begin
                                result_d   = hi_q;
                                zero_d     = (hi_q == '0);
                                negative_d = hi_q[WIDTH-1];
                            end else if (req_op == MDU_MFLO) begin
                                result_d   = lo_q;
                                zero_d     = (lo_q == '0);
                                negative_d = lo_q[WIDTH-1];
                            end else begin
                                result_d   = '0;
                                zero_d     = 1'b0;
                                negative_d = 1'b0;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (opq_is_mul) begin
                        work_hi_d = madd[WIDTH:1];
                        work_lo_d = {madd[0], work_lo_q[WIDTH-1:1]};
                    end else begin
                        work_hi_d = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], qbit};
                    end
                    if (count_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    hi_d       = fix_hi;
                    lo_d       = fix_lo;
                    result_d   = fix_lo;
                    zero_d     = (fix_lo == '0);
                    negative_d = fix_lo[WIDTH-1];
                    overflow_d = 1'b0;
                    dbz_d      = dz_q;
                    state_d    = ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            count_q    <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            negr_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            count_q    <= count_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            mcand_q    <= mcand_d;
            neg_q      <= neg_d;
            negr_q     <= negr_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            dbz_q      <= dbz_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_DONE);
    assign result      = result_q;
    assign zero        = zero_q;
    assign negative    = negative_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
